// File: rtl/alu_ctrl_pkg.sv
// Opcode constants and datapath width shared by
// the ALU and the decoder that drives ALUOPCtrl.
package alu_ctrl_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_ADDU = 5'd1;
  localparam logic [4:0] ALU_SUB  = 5'd2;
  localparam logic [4:0] ALU_SUBU = 5'd3;
  localparam logic [4:0] ALU_AND  = 5'd4;
  localparam logic [4:0] ALU_OR   = 5'd5;
  localparam logic [4:0] ALU_XOR  = 5'd6;
  localparam logic [4:0] ALU_NOR  = 5'd7;
  localparam logic [4:0] ALU_SLT  = 5'd8;
  localparam logic [4:0] ALU_SLTU = 5'd9;
  localparam logic [4:0] ALU_SLL  = 5'd10;
  localparam logic [4:0] ALU_SRL  = 5'd11;
  localparam logic [4:0] ALU_SRA  = 5'd12;
  localparam logic [4:0] ALU_LUI  = 5'd13;

endpackage

// File: rtl/alu_shifter.sv
// Barrel shifter producing all three shift flavours;
// the ALU picks the one its opcode asks for.
module alu_shifter
  import alu_ctrl_pkg::*;
(
  input  logic [ALU_WIDTH-1:0] val,
  input  logic [4:0]           shamt,
  output logic [ALU_WIDTH-1:0] sll_o,
  output logic [ALU_WIDTH-1:0] srl_o,
  output logic [ALU_WIDTH-1:0] sra_o
);

  // Logical left/right and sign-filling right shift
  always_comb begin
    sll_o = val << shamt;
    srl_o = val >> shamt;
    sra_o = $unsigned($signed(val) >>> shamt);
  end

endmodule

// File: rtl/alu_core.sv
// 32-bit MIPS-style ALU: combinational result/flags
// plus a sticky signed-overflow status register.
module alu_core
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic [4:0]       ALUOPCtrl,
  input  logic             ovf_clr,
  output logic             zero,
  output logic             ovf,
  output logic [WIDTH-1:0] aluout,
  output logic             ovf_sticky
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             ovf_add;
  logic             ovf_sub;
  logic             lt_s;
  logic             lt_u;
  logic [WIDTH-1:0] sll_r;
  logic [WIDTH-1:0] srl_r;
  logic [WIDTH-1:0] sra_r;
  logic [WIDTH-1:0] res_c;
  logic             ovf_c;
  logic             ovf_sticky_d;
  logic             ovf_sticky_q;

  alu_shifter u_shifter (
    .val   (srcB),
    .shamt (srcA[4:0]),
    .sll_o (sll_r),
    .srl_o (srl_r),
    .sra_o (sra_r)
  );

  // Shared adder/subtractor, overflow detect and compares
  always_comb begin
    sum     = srcA + srcB;
    diff    = srcA - srcB;
    ovf_add = (srcA[WIDTH-1] == srcB[WIDTH-1])
           && (sum[WIDTH-1] != srcA[WIDTH-1]);
    ovf_sub = (srcA[WIDTH-1] != srcB[WIDTH-1])
           && (diff[WIDTH-1] != srcA[WIDTH-1]);
    lt_s    = $signed(srcA) < $signed(srcB);
    lt_u    = srcA < srcB;
  end

  // Result mux; reserved opcodes fall to zero
  always_comb begin
    res_c = '0;
    ovf_c = 1'b0;
    case (ALUOPCtrl)
      ALU_ADD: begin
        res_c = sum;
        ovf_c = ovf_add;
      end
      ALU_ADDU: res_c = sum;
      ALU_SUB: begin
        res_c = diff;
        ovf_c = ovf_sub;
      end
      ALU_SUBU: res_c = diff;
      ALU_AND:  res_c = srcA & srcB;
      ALU_OR:   res_c = srcA | srcB;
      ALU_XOR:  res_c = srcA ^ srcB;
      ALU_NOR:  res_c = ~(srcA | srcB);
      ALU_SLT:  res_c = {{(WIDTH-1){1'b0}}, lt_s};
      ALU_SLTU: res_c = {{(WIDTH-1){1'b0}}, lt_u};
      ALU_SLL:  res_c = sll_r;
      ALU_SRL:  res_c = srl_r;
      ALU_SRA:  res_c = sra_r;
      ALU_LUI:  res_c = {srcB[15:0], 16'h0000};
      default: begin
        res_c = '0;
        ovf_c = 1'b0;
      end
    endcase
  end

  assign aluout = res_c;
  assign ovf    = ovf_c;
  assign zero   = (res_c == '0);

  // Next sticky value: clear wins over a new overflow
  always_comb begin
    ovf_sticky_d = ovf_sticky_q | ovf_c;
    if (ovf_clr) ovf_sticky_d = 1'b0;
  end

  // Sticky overflow register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ovf_sticky_q <= 1'b0;
    else       ovf_sticky_q <= ovf_sticky_d;
  end

  assign ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_alu_core.sv
// Directed self-checking bench for alu_core.
// Each task drives one scenario and checks inline.
module tb_alu_core;
  import alu_ctrl_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic [4:0]  ALUOPCtrl;
  logic        ovf_clr;
  logic        zero;
  logic        ovf;
  logic [31:0] aluout;
  logic        ovf_sticky;

  int errors = 0;
  int checks = 0;

  alu_core dut (
    .clk        (clk),
    .reset      (reset),
    .srcA       (srcA),
    .srcB       (srcB),
    .ALUOPCtrl  (ALUOPCtrl),
    .ovf_clr    (ovf_clr),
    .zero       (zero),
    .ovf        (ovf),
    .aluout     (aluout),
    .ovf_sticky (ovf_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply(input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [4:0] op);
    srcA = a;
    srcB = b;
    ALUOPCtrl = op;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ovf_clr = 1'b0;
    apply(32'h0, 32'h0, ALU_ADD);
    @(negedge clk);
    checks++;
    if (ovf_sticky !== 1'b0) begin
      errors++;
      $display("FAIL reset_sticky: got %b want 0", ovf_sticky);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (ovf_sticky !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_sticky: got %b want 0", ovf_sticky);
    end
  endtask

  task automatic test_add();
    apply(32'h7FFFFFFF, 32'h00000001, ALU_ADD);
    checks++;
    if (aluout !== 32'h80000000 || ovf !== 1'b1 || zero !== 1'b0) begin
      errors++;
      $display("FAIL add_ovf: got %h ovf=%b z=%b want 80000000 1 0",
               aluout, ovf, zero);
    end
    apply(32'h7FFFFFFF, 32'h00000001, ALU_ADDU);
    checks++;
    if (aluout !== 32'h80000000 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL addu: got %h ovf=%b want 80000000 0", aluout, ovf);
    end
    apply(32'hFFFFFFFF, 32'h00000003, ALU_ADD);
    checks++;
    if (aluout !== 32'h00000002 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL add_neg: got %h ovf=%b want 00000002 0", aluout, ovf);
    end
    apply(32'h80000000, 32'h80000000, ALU_ADD);
    checks++;
    if (aluout !== 32'h0 || ovf !== 1'b1 || zero !== 1'b1) begin
      errors++;
      $display("FAIL add_negovf: got %h ovf=%b z=%b want 0 1 1",
               aluout, ovf, zero);
    end
  endtask

  task automatic test_sub();
    apply(32'h12345678, 32'h12345678, ALU_SUB);
    checks++;
    if (aluout !== 32'h0 || zero !== 1'b1 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL sub_zero: got %h z=%b ovf=%b want 0 1 0",
               aluout, zero, ovf);
    end
    apply(32'h80000000, 32'h00000001, ALU_SUB);
    checks++;
    if (aluout !== 32'h7FFFFFFF || ovf !== 1'b1) begin
      errors++;
      $display("FAIL sub_ovf: got %h ovf=%b want 7fffffff 1", aluout, ovf);
    end
    apply(32'h80000000, 32'h00000001, ALU_SUBU);
    checks++;
    if (aluout !== 32'h7FFFFFFF || ovf !== 1'b0) begin
      errors++;
      $display("FAIL subu: got %h ovf=%b want 7fffffff 0", aluout, ovf);
    end
    apply(32'h00000005, 32'h00000007, ALU_SUB);
    checks++;
    if (aluout !== 32'hFFFFFFFE || ovf !== 1'b0) begin
      errors++;
      $display("FAIL sub_neg: got %h ovf=%b want fffffffe 0", aluout, ovf);
    end
  endtask

  task automatic test_compare();
    apply(32'hFFFFFFFF, 32'h00000001, ALU_SLT);
    checks++;
    if (aluout !== 32'h1 || zero !== 1'b0) begin
      errors++;
      $display("FAIL slt: got %h z=%b want 1 0", aluout, zero);
    end
    apply(32'hFFFFFFFF, 32'h00000001, ALU_SLTU);
    checks++;
    if (aluout !== 32'h0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL sltu: got %h z=%b want 0 1", aluout, zero);
    end
    apply(32'h00000001, 32'hFFFFFFFF, ALU_SLTU);
    checks++;
    if (aluout !== 32'h1) begin
      errors++;
      $display("FAIL sltu_rev: got %h want 1", aluout);
    end
  endtask

  task automatic test_logic();
    apply(32'h0, 32'h0, ALU_NOR);
    checks++;
    if (aluout !== 32'hFFFFFFFF || zero !== 1'b0) begin
      errors++;
      $display("FAIL nor: got %h z=%b want ffffffff 0", aluout, zero);
    end
    apply(32'hF0F0F0F0, 32'hFF00FF00, ALU_AND);
    checks++;
    if (aluout !== 32'hF000F000) begin
      errors++;
      $display("FAIL and: got %h want f000f000", aluout);
    end
    apply(32'hF0F0F0F0, 32'hFF00FF00, ALU_OR);
    checks++;
    if (aluout !== 32'hFFF0FFF0) begin
      errors++;
      $display("FAIL or: got %h want fff0fff0", aluout);
    end
    apply(32'hF0F0F0F0, 32'hFF00FF00, ALU_XOR);
    checks++;
    if (aluout !== 32'h0FF00FF0) begin
      errors++;
      $display("FAIL xor: got %h want 0ff00ff0", aluout);
    end
  endtask

  task automatic test_shift();
    apply(32'h00000004, 32'h80000000, ALU_SRA);
    checks++;
    if (aluout !== 32'hF8000000) begin
      errors++;
      $display("FAIL sra: got %h want f8000000", aluout);
    end
    apply(32'h00000004, 32'h80000000, ALU_SRL);
    checks++;
    if (aluout !== 32'h08000000) begin
      errors++;
      $display("FAIL srl: got %h want 08000000", aluout);
    end
    apply(32'h00000023, 32'h00000001, ALU_SLL);
    checks++;
    if (aluout !== 32'h00000008) begin
      errors++;
      $display("FAIL sll: got %h want 00000008", aluout);
    end
    apply(32'hFFFFFFE0, 32'h9ABCDEF0, ALU_SRA);
    checks++;
    if (aluout !== 32'h9ABCDEF0) begin
      errors++;
      $display("FAIL sra_zero_amt: got %h want 9abcdef0", aluout);
    end
    apply(32'h0000001F, 32'h80000000, ALU_SRL);
    checks++;
    if (aluout !== 32'h00000001) begin
      errors++;
      $display("FAIL srl_31: got %h want 00000001", aluout);
    end
    apply(32'h12345678, 32'h0000ABCD, ALU_LUI);
    checks++;
    if (aluout !== 32'hABCD0000) begin
      errors++;
      $display("FAIL lui: got %h want abcd0000", aluout);
    end
  endtask

  task automatic test_reserved();
    apply(32'h7FFFFFFF, 32'h00000001, 5'd31);
    checks++;
    if (aluout !== 32'h0 || zero !== 1'b1 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL rsv31: got %h z=%b ovf=%b want 0 1 0",
               aluout, zero, ovf);
    end
    apply(32'hDEADBEEF, 32'hCAFEF00D, 5'd14);
    checks++;
    if (aluout !== 32'h0 || zero !== 1'b1 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL rsv14: got %h z=%b ovf=%b want 0 1 0",
               aluout, zero, ovf);
    end
  endtask

  task automatic test_sticky();
    @(negedge clk);
    apply(32'h7FFFFFFF, 32'h00000001, ALU_ADD);
    @(posedge clk);
    #1;
    checks++;
    if (ovf_sticky !== 1'b1) begin
      errors++;
      $display("FAIL sticky_set: got %b want 1", ovf_sticky);
    end
    @(negedge clk);
    apply(32'h00000001, 32'h00000001, ALU_ADD);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ovf_sticky !== 1'b1) begin
      errors++;
      $display("FAIL sticky_hold: got %b want 1", ovf_sticky);
    end
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (ovf_sticky !== 1'b0) begin
      errors++;
      $display("FAIL sticky_async_rst: got %b want 0", ovf_sticky);
    end
    checks++;
    if (aluout !== 32'h00000002) begin
      errors++;
      $display("FAIL comb_in_reset: got %h want 00000002", aluout);
    end
    @(negedge clk);
    reset = 1'b0;
    apply(32'h80000000, 32'h00000001, ALU_SUB);
    @(posedge clk);
    #1;
    checks++;
    if (ovf_sticky !== 1'b1) begin
      errors++;
      $display("FAIL sticky_sub: got %b want 1", ovf_sticky);
    end
    @(negedge clk);
    ovf_clr = 1'b1;
    apply(32'h7FFFFFFF, 32'h00000001, ALU_ADD);
    @(posedge clk);
    #1;
    checks++;
    if (ovf_sticky !== 1'b0) begin
      errors++;
      $display("FAIL sticky_clr_prio: got %b want 0", ovf_sticky);
    end
    @(negedge clk);
    ovf_clr = 1'b0;
    apply(32'h00000000, 32'h00000000, ALU_ADDU);
    @(posedge clk);
    #1;
    checks++;
    if (ovf_sticky !== 1'b0) begin
      errors++;
      $display("FAIL sticky_stays_clr: got %b want 0", ovf_sticky);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_compare();
    test_logic();
    test_shift();
    test_reserved();
    test_sticky();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
